output_reader: RTL and testbench
================================

OUTPUT_READER -- requirements
Module: output_reader

Interface
REQ-001 SHALL have parameter DROP_ZERO_LT, default 1: when 1, entries whose lifetime is 0 are discarded instead of sent.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1 bit: permits new pops from the FIFO; does not abort a word already being sent.
REQ-005 SHALL have port fifo_data_out, input, 32 bits: the output_fifo head entry, {value[31:16], lifetime[15:0]}, valid combinationally while fifo_empty is 0.
REQ-006 SHALL have port fifo_empty, input, 1 bit: output_fifo empty flag.
REQ-007 SHALL have port fifo_de, output, 1 bit: dequeue strobe; one pulse pops one entry at that rising edge.
REQ-008 SHALL have port host_data, output, 16 bits: current half-word presented to the host.
REQ-009 SHALL have port host_valid, output, 1 bit: host_data is valid.
REQ-010 SHALL have port host_ready, input, 1 bit: host accepts host_data on a rising edge where host_valid and host_ready are both 1.
REQ-011 SHALL have port host_last, output, 1 bit: high on the lifetime half, the second half of an entry.
REQ-012 SHALL have port sent_count, output, 16 bits: entries fully delivered, saturating.
REQ-013 SHALL have port drop_count, output, 16 bits: entries discarded for zero lifetime, saturating.

Function
REQ-014 SHALL implement the FSM states IDLE, SEND_HI and SEND_LO.
REQ-015 SHALL pop in IDLE when enable=1 and fifo_empty=0: assert fifo_de combinationally for that cycle and capture fifo_data_out into a 32-bit hold register at the same edge.
REQ-016 SHALL, when DROP_ZERO_LT=1 and fifo_data_out[15:0]==0 at the pop edge, discard the entry, stay in IDLE, and increment drop_count; otherwise it SHALL move to SEND_HI.
REQ-017 SHALL, in SEND_HI, drive host_valid=1, host_data=hold[31:16] and host_last=0, and move to SEND_LO on handshake.
REQ-018 SHALL, in SEND_LO, drive host_valid=1, host_data=hold[15:0] and host_last=1; on handshake it SHALL increment sent_count.
REQ-019 SHALL, on the SEND_LO handshake with enable=1 and fifo_empty=0, pop the next entry in that same cycle, load hold, and go to SEND_HI or apply the REQ-016 drop rule, giving zero idle cycles between entries; otherwise it SHALL go to IDLE.
REQ-020 SHALL hold host_data and host_last stable while host_valid=1 and host_ready=0, for any number of cycles.
REQ-021 SHALL assert fifo_de only when fifo_empty=0, never more than once per cycle, and never while a held entry is undelivered.
REQ-022 SHALL limit latency to 1 cycle from a pop edge to host_valid=1, and limit throughput to 1 entry per 2 cycles with host_ready held at 1.
REQ-023 SHALL, when enable falls mid-entry, still deliver that entry completely, then stop popping.
REQ-024 SHALL make sent_count and drop_count saturate at 16'hFFFF with no wrap; when a delivery and a drop occur in the same cycle, each counter SHALL update independently.
REQ-025 SHALL drive host_valid=0 in IDLE, and host_data in IDLE SHALL be don't-care, driven to 0.

Reset
REQ-026 SHALL, on reset=1 at a rising edge, force state=IDLE, hold=0, sent_count=0 and drop_count=0, giving host_valid=0, host_last=0, host_data=0 and fifo_de=0.
REQ-027 SHALL, on reset mid-entry, abandon the held entry (it is lost, not re-queued) and assert no fifo_de during the reset cycle.

Structure
REQ-028 SHALL place the FSM state encoding, the field positions (VALUE_MSB=31, VALUE_LSB=16, LT_MSB=15, LT_LSB=0) and the 16-bit counter saturation constant in the shared neural processor package.
REQ-029 SHALL use one sub-module, sat_counter16, a 16-bit saturating incrementer with synchronous reset, instantiated twice for sent_count and drop_count.
REQ-030 SHALL instantiate output_reader in neural_processor with its FIFO ports wired to output_fifo.

Verification
REQ-031 SHALL cover a basic transfer: FIFO head 32'hfffe0001, host_ready=1 -> fifo_de pulse, then host_data 16'hfffe with last=0, then 16'h0001 with last=1, sent_count=1.
REQ-032 SHALL cover backpressure: host_ready=0 for 5 cycles during SEND_HI -> host_data stays 16'hfffe and fifo_de stays 0; ready high -> the transfer completes normally.
REQ-033 SHALL cover the zero-lifetime drop: FIFO holds 32'h00050000 then 32'h00070002 -> the first entry is popped with no host_valid and drop_count=1; the host receives 16'h0007, 16'h0002.
REQ-034 SHALL cover back-to-back entries: 3 entries queued, ready=1 -> 6 consecutive valid cycles with no gap, fifo_de pulsing on cycles 0, 2 and 4, sent_count=3.
REQ-035 SHALL cover reset mid-operation: reset asserted in SEND_LO -> next cycle host_valid=0, counters 0, no fifo_de; the remaining FIFO entries are sent after reset releases.
REQ-036 SHALL cover enable gating: enable=0 with a non-empty FIFO for 10 cycles -> no fifo_de and no host_valid; enable dropped mid-entry -> that entry finishes and then no further pop occurs.

Source files
------------

// File: rtl/output_reader_pkg.sv
// Shared definitions for the output reader: FSM encoding, entry field
// positions and counter saturation value.
package output_reader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_HI = 2'd1,
        SEND_LO = 2'd2
    } rd_state_t;

    // Entry layout: {value, lifetime}
    localparam int VALUE_MSB = 31;
    localparam int VALUE_LSB = 16;
    localparam int LT_MSB    = 15;
    localparam int LT_LSB    = 0;

    localparam logic [15:0] CNT_SAT = 16'hFFFF;

    // True when the entry carries a zero lifetime field.
    function automatic logic is_zero_lt(input logic [31:0] entry);
        return (entry[LT_MSB:LT_LSB] == 16'd0);
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit incrementer that sticks at its maximum instead of wrapping.
module sat_counter16
    import output_reader_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] count_reg;

    // Count up on inc until the saturation value is reached.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != CNT_SAT)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/output_reader.sv
// Pops {value, lifetime} entries from the output FIFO and presents each as
// two half-words to the host (value first, lifetime last), optionally
// discarding zero-lifetime entries.
module output_reader
    import output_reader_pkg::*;
#(
    parameter logic DROP_ZERO_LT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] fifo_data_out,
    input  logic        fifo_empty,
    output logic        fifo_de,
    output logic [15:0] host_data,
    output logic        host_valid,
    input  logic        host_ready,
    output logic        host_last,
    output logic [15:0] sent_count,
    output logic [15:0] drop_count
);

    rd_state_t   state_reg, state_next;
    logic [31:0] hold_reg;
    logic        can_pop;
    logic        zero_lt;
    logic        pop;
    logic        drop;
    logic        sent_inc;

    // A pop is only ever considered outside reset, with data available.
    assign can_pop = enable && !fifo_empty && !reset;
    assign zero_lt = DROP_ZERO_LT && is_zero_lt(fifo_data_out);

    // Next-state, pop decision and host-side outputs.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        drop       = 1'b0;
        sent_inc   = 1'b0;
        host_valid = 1'b0;
        host_data  = '0;
        host_last  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (can_pop) begin
                    pop        = 1'b1;
                    drop       = zero_lt;
                    state_next = zero_lt ? IDLE : SEND_HI;
                end
            end
            SEND_HI: begin
                host_valid = 1'b1;
                host_data  = hold_reg[VALUE_MSB:VALUE_LSB];
                if (host_ready) begin
                    state_next = SEND_LO;
                end
            end
            SEND_LO: begin
                host_valid = 1'b1;
                host_data  = hold_reg[LT_MSB:LT_LSB];
                host_last  = 1'b1;
                if (host_ready) begin
                    sent_inc = 1'b1;
                    // Chain straight into the next entry when one is waiting.
                    if (can_pop) begin
                        pop        = 1'b1;
                        drop       = zero_lt;
                        state_next = zero_lt ? IDLE : SEND_HI;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign fifo_de = pop;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture the popped entry; dropped entries are captured too but never shown.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_reg <= '0;
        end else if (pop) begin
            hold_reg <= fifo_data_out;
        end
    end

    sat_counter16 u_sent_cnt (
        .clk   (clk),
        .srst  (reset),
        .inc   (sent_inc),
        .count (sent_count)
    );

    sat_counter16 u_drop_cnt (
        .clk   (clk),
        .srst  (reset),
        .inc   (drop),
        .count (drop_count)
    );

endmodule

// File: tb/tb_output_reader.sv
// Bench for output_reader: FIFO model, handshake monitor and a stream-level
// reference model (each non-zero-lifetime entry yields value then lifetime).
module tb_output_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] fifo_data_out;
    logic        fifo_empty;
    logic        fifo_de;
    logic [15:0] host_data;
    logic        host_valid;
    logic        host_ready;
    logic        host_last;
    logic [15:0] sent_count;
    logic [15:0] drop_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    output_reader #(.DROP_ZERO_LT(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .fifo_de       (fifo_de),
        .host_data     (host_data),
        .host_valid    (host_valid),
        .host_ready    (host_ready),
        .host_last     (host_last),
        .sent_count    (sent_count),
        .drop_count    (drop_count)
    );

    // FIFO model: circular store, head shown combinationally.
    logic [31:0] mem [0:1023];
    logic [9:0]  rd = '0;
    logic [9:0]  wr = '0;
    assign fifo_empty    = (rd == wr);
    assign fifo_data_out = mem[rd];

    always @(posedge clk) begin
        if (fifo_de === 1'b1 && rd != wr) rd <= rd + 10'd1;
    end

    // Reference model: expected host words and counter totals.
    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];
    int exp_sent = 0;
    int exp_drop = 0;

    always @(negedge clk) begin
        if (reset === 1'b0 && host_valid === 1'b1 && host_ready === 1'b1)
            obs_q.push_back({host_last, host_data});
    end

    task automatic model_add(input logic [31:0] e);
        if (e[15:0] == 16'd0) begin
            exp_drop++;
        end else begin
            exp_sent++;
            exp_q.push_back({1'b0, e[31:16]});
            exp_q.push_back({1'b1, e[15:0]});
        end
    endtask

    task automatic push(input logic [31:0] e);
        mem[wr] = e;
        wr = wr + 10'd1;
        model_add(e);
    endtask

    function automatic int stream_diff();
        int d = 0;
        if (obs_q.size() != exp_q.size()) return -1;
        foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    function automatic logic [31:0] rand_entry_nz();
        logic [15:0] v = 16'($urandom);
        logic [15:0] l = 16'($urandom_range(1, 65535));
        return {v, l};
    endfunction

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stream;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        enable = 1'b1;
        host_ready = 1'b1;
        while (!(fifo_empty && !host_valid) && n < 500) begin
            nxt;
            n++;
        end
        tests++;
        if (n >= 500) begin fails++; $display("FAIL %s_drain_timeout got=%0d cycles want<500", tag, n); end
        nxt;
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0; host_ready = 1'b0;
        nxt; nxt;
        @(negedge clk);
        tests++; if (host_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0h want=0", host_valid); end
        tests++; if (host_last !== 1'b0) begin fails++; $display("FAIL reset_last got=%0h want=0", host_last); end
        tests++; if (host_data !== 16'h0) begin fails++; $display("FAIL reset_data got=%0h want=0", host_data); end
        tests++; if (fifo_de !== 1'b0) begin fails++; $display("FAIL reset_de got=%0h want=0", fifo_de); end
        tests++; if (sent_count !== 16'h0) begin fails++; $display("FAIL reset_sent got=%0h want=0", sent_count); end
        tests++; if (drop_count !== 16'h0) begin fails++; $display("FAIL reset_drop got=%0h want=0", drop_count); end
        reset = 1'b0;
        clear_stream(); exp_sent = 0; exp_drop = 0;
        nxt;
    endtask

    task automatic test_basic;
        clear_stream();
        enable = 1'b1; host_ready = 1'b1;
        push(32'hfffe0001);
        @(negedge clk);
        tests++; if (fifo_de !== 1'b1) begin fails++; $display("FAIL basic_pop got=%0h want=1", fifo_de); end
        tests++; if (host_valid !== 1'b0) begin fails++; $display("FAIL basic_idle_valid got=%0h want=0", host_valid); end
        nxt; @(negedge clk);
        tests++; if ({host_valid, host_last, host_data} !== {2'b10, 16'hfffe})
            begin fails++; $display("FAIL basic_hi got=%0h/%0h/%0h want=1/0/fffe", host_valid, host_last, host_data); end
        nxt; @(negedge clk);
        tests++; if ({host_valid, host_last, host_data} !== {2'b11, 16'h0001})
            begin fails++; $display("FAIL basic_lo got=%0h/%0h/%0h want=1/1/0001", host_valid, host_last, host_data); end
        nxt; @(negedge clk);
        tests++; if (host_valid !== 1'b0) begin fails++; $display("FAIL basic_after_valid got=%0h want=0", host_valid); end
        tests++; if (sent_count !== 16'(exp_sent)) begin fails++; $display("FAIL basic_sent got=%0d want=%0d", sent_count, exp_sent); end
        nxt;
        tests++; if (stream_diff() != 0) begin fails++; $display("FAIL basic_stream got=%0d diffs want=0", stream_diff()); end
    endtask

    task automatic test_backpressure;
        clear_stream();
        enable = 1'b1; host_ready = 1'b0;
        push(32'hfffe0001);
        push(rand_entry_nz());
        @(negedge clk);
        tests++; if (fifo_de !== 1'b1) begin fails++; $display("FAIL bp_pop got=%0h want=1", fifo_de); end
        nxt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++; if ({host_valid, host_last, host_data} !== {2'b10, 16'hfffe})
                begin fails++; $display("FAIL bp_hold_%0d got=%0h/%0h/%0h want=1/0/fffe", i, host_valid, host_last, host_data); end
            tests++; if (fifo_de !== 1'b0) begin fails++; $display("FAIL bp_no_pop_%0d got=%0h want=0", i, fifo_de); end
            nxt;
        end
        drain("bp");
        tests++; if (stream_diff() != 0) begin fails++; $display("FAIL bp_stream got=%0d diffs want=0", stream_diff()); end
        tests++; if (sent_count !== 16'(exp_sent)) begin fails++; $display("FAIL bp_sent got=%0d want=%0d", sent_count, exp_sent); end
    endtask

    task automatic test_drop;
        clear_stream();
        enable = 1'b1; host_ready = 1'b1;
        push(32'h00050000);
        push(32'h00070002);
        @(negedge clk);
        tests++; if ({fifo_de, host_valid} !== 2'b10) begin fails++; $display("FAIL drop_pop1 got=%0h/%0h want=1/0", fifo_de, host_valid); end
        nxt; @(negedge clk);
        tests++; if ({fifo_de, host_valid} !== 2'b10) begin fails++; $display("FAIL drop_pop2 got=%0h/%0h want=1/0", fifo_de, host_valid); end
        tests++; if (drop_count !== 16'(exp_drop)) begin fails++; $display("FAIL drop_count got=%0d want=%0d", drop_count, exp_drop); end
        nxt; @(negedge clk);
        tests++; if ({host_valid, host_last, host_data} !== {2'b10, 16'h0007})
            begin fails++; $display("FAIL drop_hi got=%0h/%0h/%0h want=1/0/0007", host_valid, host_last, host_data); end
        nxt; @(negedge clk);
        tests++; if ({host_valid, host_last, host_data} !== {2'b11, 16'h0002})
            begin fails++; $display("FAIL drop_lo got=%0h/%0h/%0h want=1/1/0002", host_valid, host_last, host_data); end
        nxt;
        drain("drop");
        tests++; if (stream_diff() != 0) begin fails++; $display("FAIL drop_stream got=%0d diffs want=0", stream_diff()); end
    endtask

    task automatic test_back_to_back;
        logic exp_de;
        clear_stream();
        enable = 1'b1; host_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(rand_entry_nz());
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            exp_de = (c == 0 || c == 2 || c == 4);
            tests++; if (fifo_de !== exp_de) begin fails++; $display("FAIL b2b_de_c%0d got=%0h want=%0h", c, fifo_de, exp_de); end
            tests++; if (host_valid !== (c >= 1)) begin fails++; $display("FAIL b2b_valid_c%0d got=%0h want=%0h", c, host_valid, c >= 1); end
            nxt;
        end
        @(negedge clk);
        tests++; if (host_valid !== 1'b0) begin fails++; $display("FAIL b2b_end_valid got=%0h want=0", host_valid); end
        tests++; if (sent_count !== 16'(exp_sent)) begin fails++; $display("FAIL b2b_sent got=%0d want=%0d", sent_count, exp_sent); end
        nxt;
        tests++; if (stream_diff() != 0) begin fails++; $display("FAIL b2b_stream got=%0d diffs want=0", stream_diff()); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] e2;
        clear_stream();
        enable = 1'b1; host_ready = 1'b1;
        e2 = rand_entry_nz();
        push(rand_entry_nz());
        push(e2);
        nxt; nxt;               // pop edge, then SEND_HI handshake: now in SEND_LO
        reset = 1'b1;
        @(negedge clk);
        tests++; if (fifo_de !== 1'b0) begin fails++; $display("FAIL rstmid_de got=%0h want=0", fifo_de); end
        nxt;
        reset = 1'b0;
        @(negedge clk);
        tests++; if (host_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got=%0h want=0", host_valid); end
        tests++; if (sent_count !== 16'h0) begin fails++; $display("FAIL rstmid_sent got=%0d want=0", sent_count); end
        tests++; if (drop_count !== 16'h0) begin fails++; $display("FAIL rstmid_drop got=%0d want=0", drop_count); end
        clear_stream(); exp_sent = 0; exp_drop = 0;
        model_add(e2);
        nxt;
        drain("rstmid");
        tests++; if (stream_diff() != 0) begin fails++; $display("FAIL rstmid_stream got=%0d diffs want=0", stream_diff()); end
        tests++; if (sent_count !== 16'(exp_sent)) begin fails++; $display("FAIL rstmid_sent_after got=%0d want=%0d", sent_count, exp_sent); end
    endtask

    task automatic test_enable_gate;
        clear_stream();
        enable = 1'b0; host_ready = 1'b1;
        push(rand_entry_nz());
        push(rand_entry_nz());
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++; if ({fifo_de, host_valid} !== 2'b00) begin fails++; $display("FAIL en_off_%0d got=%0h/%0h want=0/0", i, fifo_de, host_valid); end
            nxt;
        end
        enable = 1'b1;
        @(negedge clk);
        tests++; if (fifo_de !== 1'b1) begin fails++; $display("FAIL en_pop got=%0h want=1", fifo_de); end
        nxt;
        enable = 1'b0;
        @(negedge clk);
        tests++; if ({host_valid, host_last} !== 2'b10) begin fails++; $display("FAIL en_mid_hi got=%0h/%0h want=1/0", host_valid, host_last); end
        nxt; @(negedge clk);
        tests++; if ({host_valid, host_last, fifo_de} !== 3'b110) begin fails++; $display("FAIL en_mid_lo got=%0h/%0h/%0h want=1/1/0", host_valid, host_last, fifo_de); end
        nxt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if ({fifo_de, host_valid} !== 2'b00) begin fails++; $display("FAIL en_stop_%0d got=%0h/%0h want=0/0", i, fifo_de, host_valid); end
            nxt;
        end
        drain("en");
        tests++; if (stream_diff() != 0) begin fails++; $display("FAIL en_stream got=%0d diffs want=0", stream_diff()); end
    endtask

    task automatic test_random;
        logic        have_prev = 1'b0;
        logic        p_valid, p_ready, p_last;
        logic [15:0] p_data;
        logic [15:0] l;
        clear_stream();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                l = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
                push({16'($urandom), l});
            end
            enable     = ($urandom_range(0, 4) != 0);
            host_ready = $urandom_range(0, 1) == 1;
            @(negedge clk);
            if (have_prev && p_valid && !p_ready) begin
                tests++; if ({host_valid, host_last, host_data} !== {1'b1, p_last, p_data})
                    begin fails++; $display("FAIL rnd_stable_c%0d got=%0h/%0h/%0h want=1/%0h/%0h", c, host_valid, host_last, host_data, p_last, p_data); end
            end
            if (fifo_de === 1'b1) begin
                tests++; if (fifo_empty !== 1'b0) begin fails++; $display("FAIL rnd_pop_empty_c%0d got=%0h want=0", c, fifo_empty); end
            end
            have_prev = 1'b1;
            p_valid = host_valid; p_ready = host_ready; p_last = host_last; p_data = host_data;
            nxt;
        end
        drain("rnd");
        tests++; if (stream_diff() != 0) begin fails++; $display("FAIL rnd_stream got=%0d diffs want=0 (words %0d/%0d)", stream_diff(), obs_q.size(), exp_q.size()); end
        tests++; if (sent_count !== 16'(exp_sent)) begin fails++; $display("FAIL rnd_sent got=%0d want=%0d", sent_count, exp_sent); end
        tests++; if (drop_count !== 16'(exp_drop)) begin fails++; $display("FAIL rnd_drop got=%0d want=%0d", drop_count, exp_drop); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        reset = 1'b1; enable = 1'b0; host_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        test_enable_gate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog_timeout got=expired want=finished");
        $fatal(1, "watchdog");
    end

endmodule
